// File: rtl/shift_add_mult8_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// FSM encodings and step-counter sizing.
package shift_add_mult8_pkg;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'b00,
        MUL_RUN  = 2'b01,
        MUL_DONE = 2'b10
    } mul_state_e;

    localparam int MUL_STEPS = 8;
    localparam int CNT_W     = 3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_STEPS - 1);

endpackage

// File: rtl/adder_8.sv
// Plain 8-bit ripple adder with carry-out, shared by the ALU and the
// multi-cycle multiplier.
module adder_8 (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    output logic [7:0] sum_o,
    output logic       cout_o
);

    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i};

endmodule

// File: rtl/shift_add_mult8.sv
// Sequential 8x8 -> 16-bit unsigned multiplier. One partial product per RUN
// cycle through a single time-shared adder_8, with a start/busy/done handshake.
module shift_add_mult8
    import shift_add_mult8_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    mul_state_e         state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;
    logic               cout;

    assign addend = mplier_q[0] ? mcand_q : '0;

    adder_8 u_adder (
        .a_i    (acc_q),
        .b_i    (addend),
        .sum_o  (sum),
        .cout_o (cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= MUL_IDLE;
            mcand_q   <= '0;
            acc_q     <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    // Abort outranks start in IDLE; the unused encoding falls back to IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            MUL_IDLE: if (start && !abort) state_d = MUL_RUN;
            MUL_RUN: begin
                if (abort)                  state_d = MUL_IDLE;
                else if (cnt_q == CNT_LAST) state_d = MUL_DONE;
            end
            MUL_DONE: state_d = MUL_IDLE;
            default:  state_d = MUL_IDLE;
        endcase
    end

    // The adder carry lands directly in the accumulator MSB on the shift,
    // so no separate carry flop is kept.
    always_comb begin
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        if (state_q == MUL_IDLE && start && !abort) begin
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
        end else if (state_q == MUL_RUN && !abort) begin
            acc_d    = {cout, sum[WIDTH-1:1]};
            mplier_d = {sum[0], mplier_q[WIDTH-1:1]};
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) product_d = {acc_d, mplier_d};
        end
    end

    always_comb begin
        busy = (state_q == MUL_RUN) || (state_q == MUL_DONE);
        done = (state_q == MUL_DONE);
    end

    assign product = product_q;

endmodule

// File: tb/tb_shift_add_mult8.sv
// Randomised self-checking bench for shift_add_mult8; expected products come
// from plain integer multiplication, timing from the handshake rules.
module tb_shift_add_mult8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  a = 8'h00;
    logic [7:0]  b = 8'h00;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int checkCount = 0;
    int failCount  = 0;

    shift_add_mult8 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .abort   (abort),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] refMul(input logic [7:0] x, input logic [7:0] y);
        int p;
        p = int'(x) * int'(y);
        return p[15:0];
    endfunction

    // Launch one op from IDLE; returns the negedge index (1 = first cycle after
    // the accepting edge) at which done was seen, -1 on timeout. Ends in the done cycle.
    task automatic runOp(input logic [7:0] x, input logic [7:0] y,
                         output int latency, output logic busyOk);
        @(negedge clk);
        start = 1'b1; a = x; b = y;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; a = 8'($urandom); b = 8'($urandom);
        latency = -1;
        busyOk  = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            if (k > 1) @(negedge clk);
            if (busy !== 1'b1) busyOk = 1'b0;
            if (done === 1'b1) begin
                latency = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checkCount++;
        if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        checkCount++;
        if (done !== 1'b0) begin failCount++; $display("[TB] FAIL reset_done got %b want 0", done); end
        checkCount++;
        if (product !== 16'h0000) begin failCount++; $display("[TB] FAIL reset_product got %h want 0000", product); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat; logic bOk;
        runOp(8'd13, 8'd11, lat, bOk);
        checkCount++;
        if (lat !== 9) begin failCount++; $display("[TB] FAIL basic_latency got %0d want 9", lat); end
        checkCount++;
        if (bOk !== 1'b1) begin failCount++; $display("[TB] FAIL basic_busy got %b want 1", bOk); end
        checkCount++;
        if (product !== 16'h008F) begin failCount++; $display("[TB] FAIL basic_product got %h want 008f", product); end
        @(negedge clk);
        checkCount++;
        if ({busy, done} !== 2'b00) begin failCount++; $display("[TB] FAIL basic_idle got %b want 00", {busy, done}); end
    endtask

    task automatic test_corners();
        logic [7:0] xs [5] = '{8'hFF, 8'h00, 8'hA5, 8'h01, 8'h80};
        logic [7:0] ys [5] = '{8'hFF, 8'hA5, 8'h00, 8'hFF, 8'h80};
        int lat; logic bOk; logic [15:0] expP;
        for (int i = 0; i < 5; i++) begin
            expP = refMul(xs[i], ys[i]);
            runOp(xs[i], ys[i], lat, bOk);
            checkCount++;
            if (lat !== 9) begin failCount++; $display("[TB] FAIL corner%0d_latency got %0d want 9", i, lat); end
            checkCount++;
            if (product !== expP) begin failCount++; $display("[TB] FAIL corner%0d_product got %h want %h", i, product, expP); end
        end
    endtask

    task automatic test_random();
        int lat; logic bOk; logic [7:0] x, y; logic [15:0] expP;
        for (int i = 0; i < 20; i++) begin
            x = 8'($urandom); y = 8'($urandom);
            expP = refMul(x, y);
            runOp(x, y, lat, bOk);
            checkCount++;
            if (lat !== 9 || bOk !== 1'b1) begin failCount++; $display("[TB] FAIL rand%0d_timing got lat=%0d busy=%b want 9/1", i, lat, bOk); end
            checkCount++;
            if (product !== expP) begin failCount++; $display("[TB] FAIL rand%0d_product %h*%h got %h want %h", i, x, y, product, expP); end
        end
    endtask

    task automatic test_start_while_busy();
        int doneCount = 0; int doneAt = -1; logic busyOk = 1'b1;
        @(negedge clk);
        start = 1'b1; a = 8'd2; b = 8'd3;
        @(posedge clk);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start = (k == 4); a = (k == 4) ? 8'd9 : 8'd2; b = (k == 4) ? 8'd9 : 8'd3;
            if (done === 1'b1) begin doneCount++; doneAt = k; end
            if (busy !== (k <= 9)) busyOk = 1'b0;
        end
        start = 1'b0;
        checkCount++;
        if (doneCount !== 1 || doneAt !== 9) begin failCount++; $display("[TB] FAIL busy_start_done got count=%0d at=%0d want 1 at 9", doneCount, doneAt); end
        checkCount++;
        if (busyOk !== 1'b1) begin failCount++; $display("[TB] FAIL busy_start_busy got %b want 1", busyOk); end
        checkCount++;
        if (product !== 16'h0006) begin failCount++; $display("[TB] FAIL busy_start_product got %h want 0006", product); end
    endtask

    task automatic test_abort();
        int lat; logic bOk; int doneCount = 0;
        runOp(8'd5, 8'd5, lat, bOk);
        checkCount++;
        if (product !== 16'h0019) begin failCount++; $display("[TB] FAIL abort_pre_product got %h want 0019", product); end
        @(negedge clk);
        start = 1'b1; a = 8'd7; b = 8'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkCount++;
        if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL abort_run_idle got busy=%b want 0", busy); end
        for (int k = 0; k < 12; k++) begin
            if (done === 1'b1) doneCount++;
            @(negedge clk);
        end
        checkCount++;
        if (doneCount !== 0) begin failCount++; $display("[TB] FAIL abort_run_nodone got %0d pulses want 0", doneCount); end
        checkCount++;
        if (product !== 16'h0019) begin failCount++; $display("[TB] FAIL abort_run_product got %h want 0019", product); end
        runOp(8'd7, 8'd7, lat, bOk);
        checkCount++;
        if (lat !== 9 || product !== 16'h0031) begin failCount++; $display("[TB] FAIL abort_rerun got lat=%0d product=%h want 9/0031", lat, product); end
    endtask

    task automatic test_abort_in_done();
        int lat; logic bOk; logic busySeen = 1'b0;
        runOp(8'd12, 8'd10, lat, bOk);
        abort = 1'b1;
        checkCount++;
        if (done !== 1'b1) begin failCount++; $display("[TB] FAIL abort_done_pulse got %b want 1", done); end
        @(negedge clk);
        checkCount++;
        if ({busy, done} !== 2'b00 || product !== 16'd120) begin failCount++; $display("[TB] FAIL abort_done_after got bd=%b product=%h want 00/0078", {busy, done}, product); end
        start = 1'b1; a = 8'd3; b = 8'd3;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (busy !== 1'b0) busySeen = 1'b1;
        end
        start = 1'b0; abort = 1'b0;
        checkCount++;
        if (busySeen !== 1'b0) begin failCount++; $display("[TB] FAIL abort_beats_start got busy seen=%b want 0", busySeen); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] x1, y1, x2, y2; logic [15:0] p1, p2;
        int doneCount = 0; logic okFirst = 1'b0; logic okSecond = 1'b0;
        x1 = 8'($urandom); y1 = 8'($urandom); x2 = 8'($urandom); y2 = 8'($urandom);
        p1 = refMul(x1, y1); p2 = refMul(x2, y2);
        @(negedge clk);
        start = 1'b1; a = x1; b = y1;
        @(posedge clk);
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (k == 5) begin a = x2; b = y2; end
            if (k == 11) start = 1'b0;
            if (done === 1'b1) begin
                doneCount++;
                if (k == 9 && product === p1) okFirst = 1'b1;
                if (k == 19 && product === p2) okSecond = 1'b1;
            end
        end
        checkCount++;
        if (doneCount !== 2) begin failCount++; $display("[TB] FAIL b2b_count got %0d want 2", doneCount); end
        checkCount++;
        if (okFirst !== 1'b1) begin failCount++; $display("[TB] FAIL b2b_first got ok=%b product=%h want 1/%h", okFirst, product, p1); end
        checkCount++;
        if (okSecond !== 1'b1) begin failCount++; $display("[TB] FAIL b2b_second got ok=%b product=%h want 1/%h", okSecond, product, p2); end
    endtask

    task automatic test_reset_mid_run();
        int lat; logic bOk;
        @(negedge clk);
        start = 1'b1; a = 8'hAB; b = 8'hCD;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkCount++;
        if ({busy, done} !== 2'b00 || product !== 16'h0000) begin failCount++; $display("[TB] FAIL midreset got bd=%b product=%h want 00/0000", {busy, done}, product); end
        @(negedge clk);
        rst_n = 1'b1;
        runOp(8'd16, 8'd16, lat, bOk);
        checkCount++;
        if (lat !== 9 || product !== 16'h0100) begin failCount++; $display("[TB] FAIL midreset_rerun got lat=%0d product=%h want 9/0100", lat, product); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_random();
        test_start_while_busy();
        test_abort();
        test_abort_in_done();
        test_back_to_back();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
